// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for common-cathode 7-segment digits.
// Shadow/active digit buffers, blanking gap, leading-zero suppression.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    push,
    input  logic [3:0]              push_digit,
    input  logic                    lz_blank,
    output logic [3:0]              dec_in,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] active;
    logic [NUM_DIGITS-1:0]   active_dp;

    logic                    last_cnt;
    logic                    last_idx;
    logic                    in_blank;
    logic                    shown;
    logic [NUM_DIGITS-1:0]   supp;

    assign last_cnt = (cnt == CW'(REFRESH_DIV - 1));
    assign last_idx = (idx == IW'(NUM_DIGITS - 1));
    assign in_blank = (int'(cnt) < BLANK_CYCLES);
    assign shown    = !in_blank && !supp[idx];

    // Leading-zero mask: a digit is dark when it and all above it are zero
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        supp       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (active[4*k +: 4] == 4'd0);
            supp[k]    = lz_blank && (k != 0) && upper_zero;
        end
    end

    // Slot counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= last_cnt ? '0 : cnt + CW'(1);
            if (last_cnt) begin
                idx <= last_idx ? '0 : idx + IW'(1);
            end
        end
    end

    // Shadow buffer commands, clear over load over push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
        end else if (clear) begin
            shadow    <= '0;
            shadow_dp <= '0;
        end else if (load) begin
            shadow    <= load_data;
            shadow_dp <= dp_mask;
        end else if (push) begin
            shadow <= {shadow[4*NUM_DIGITS-5:0], push_digit};
        end
    end

    // Snapshot shadow into active buffer at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= '0;
            active_dp <= '0;
        end else if (last_cnt && last_idx) begin
            active    <= shadow;
            active_dp <= shadow_dp;
        end
    end

    // Registered display drive derived from current slot state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_in      <= '0;
            dp_out      <= 1'b0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            dec_in      <= active[{idx, 2'b00} +: 4];
            dp_out      <= shown && active_dp[idx];
            digit_en    <= shown ? (NUM_DIGITS'(1) << idx) : '0;
            frame_start <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 8-cycle slot, 2 blank).
// Each frame is checked cycle by cycle against hand-chosen buffer contents.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  dp_mask = '0;
    logic        push = 1'b0;
    logic [3:0]  push_digit = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  dec_in;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Command issued inside the next checked frame
    logic        c_clear = 1'b0;
    logic        c_load = 1'b0;
    logic [15:0] c_data = '0;
    logic [3:0]  c_dp = '0;
    int          c_npush = 0;
    logic [3:0]  c_push [3];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (load),
        .load_data  (load_data),
        .dp_mask    (dp_mask),
        .push       (push),
        .push_digit (push_digit),
        .lz_blank   (lz_blank),
        .dec_in     (dec_in),
        .dp_out     (dp_out),
        .digit_en   (digit_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] en,
                              input logic [3:0] dec, input logic dp,
                              input logic fs);
        checks++;
        assert (digit_en === en) else begin
            errors++;
            $error("FAIL %s digit_en got %b want %b", tag, digit_en, en);
        end
        checks++;
        assert (dec_in === dec) else begin
            errors++;
            $error("FAIL %s dec_in got %h want %h", tag, dec_in, dec);
        end
        checks++;
        assert (dp_out === dp) else begin
            errors++;
            $error("FAIL %s dp_out got %b want %b", tag, dp_out, dp);
        end
        checks++;
        assert (frame_start === fs) else begin
            errors++;
            $error("FAIL %s frame_start got %b want %b", tag, frame_start, fs);
        end
    endtask

    // Walk one 32-cycle frame; nib/dp/show are what must appear on screen
    task automatic check_frame(input string tag, input logic [15:0] nib,
                               input logic [3:0] dpm,
                               input logic [3:0] show);
        for (int s = 0; s < 32; s++) begin
            int          d;
            logic        on;
            logic [3:0]  en;
            step();
            d  = s / 8;
            on = ((s % 8) >= 2) && show[d];
            en = on ? (4'b0001 << d) : 4'b0000;
            expect_out($sformatf("%s s%0d", tag, s), en, nib[4*d +: 4],
                       on && dpm[d], s == 0);
            if (s == 5) begin
                clear     = c_clear;
                load      = c_load;
                load_data = c_data;
                dp_mask   = c_dp;
            end else if (s == 6) begin
                clear = 1'b0;
                load  = 1'b0;
            end
            if (s >= 5 && s < 5 + c_npush) begin
                push       = 1'b1;
                push_digit = c_push[s - 5];
            end else begin
                push = 1'b0;
            end
        end
        c_clear = 1'b0;
        c_load  = 1'b0;
        c_npush = 0;
    endtask

    initial begin
        // Outputs held low while reset is asserted
        step();
        step();
        expect_out("in_reset", 4'b0000, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle frame; load 1A3F, dp on digit 2, must wait a frame
        c_load = 1'b1;
        c_data = 16'h1A3F;
        c_dp   = 4'b0100;
        check_frame("idle0", 16'h0000, 4'b0000, 4'b1111);

        // Loaded value visible; push 5,7,9 shifts 1A3F to F579
        c_npush   = 3;
        c_push[0] = 4'h5;
        c_push[1] = 4'h7;
        c_push[2] = 4'h9;
        check_frame("load1A3F", 16'h1A3F, 4'b0100, 4'b1111);

        // Push result with DP mask retained; load 0042 for lz test
        c_load = 1'b1;
        c_data = 16'h0042;
        c_dp   = 4'b0000;
        check_frame("push", 16'hF579, 4'b0100, 4'b1111);

        // Leading-zero suppression hides digits 2 and 3
        lz_blank = 1'b1;
        c_load   = 1'b1;
        c_data   = 16'h0000;
        c_dp     = 4'b0000;
        check_frame("lz0042", 16'h0042, 4'b0000, 4'b0011);

        // All zero: only digit 0 remains lit
        c_load = 1'b1;
        c_data = 16'hFFFF;
        c_dp   = 4'b1111;
        check_frame("lz0000", 16'h0000, 4'b0000, 4'b0001);

        // FFFF with all DPs; then clear+load+push together
        lz_blank  = 1'b0;
        c_clear   = 1'b1;
        c_load    = 1'b1;
        c_data    = 16'h1234;
        c_dp      = 4'b1111;
        c_npush   = 1;
        c_push[0] = 4'h7;
        check_frame("ffff", 16'hFFFF, 4'b1111, 4'b1111);

        // Clear wins; load 1234 for the reset test
        c_load = 1'b1;
        c_data = 16'h1234;
        c_dp   = 4'b0100;
        check_frame("clrwin", 16'h0000, 4'b0000, 4'b1111);

        // Run into SHOW of digit 2, then assert reset mid-slot
        for (int i = 0; i < 19; i++) begin
            step();
        end
        expect_out("pre_rst", 4'b0100, 4'h2, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 4'b0000, 4'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Scan restarts at digit 0 with shadow contents lost
        check_frame("after_rst", 16'h0000, 4'b0000, 4'b1111);
        check_frame("after_rst2", 16'h0000, 4'b0000, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
